// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS-subset CPU: decodes OPCODE/FUNCT/flags into datapath controls.
// Optional build macro CTRL_OVF_EXC_EN: add/sub/addi overflow traps to the exception path instead of writing back.
module multicycle_ctrl #(
   parameter int MEM_WAIT = 1,
   parameter int CNT_W    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OPCODE,
   input  logic [5:0] FUNCT,
   input  logic       Of,
   input  logic       Eq,
   output logic       PC_w,
   output logic       MEM_w,
   output logic       IR_w,
   output logic       MDR_w,
   output logic       RB_w,
   output logic       AB_w,
   output logic       ALUOut_w,
   output logic       EPC_w,
   output logic [2:0] ULA_c,
   output logic       M_IORD,
   output logic       M_WREG,
   output logic       M_WDATA,
   output logic [1:0] M_ULAA,
   output logic [1:0] M_ULAB,
   output logic [1:0] M_PCSRC,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_WB_R     = 4'd4,
      S_EXEC_I   = 4'd5,
      S_WB_I     = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_WB_LW    = 4'd9,
      S_MEM_WR   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_EXC      = 4'd13,
      S_EXC_VEC  = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;

   localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(MEM_WAIT);

   function automatic logic funct_valid(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
   endfunction

   function automatic logic [2:0] alu_from_funct(input logic [5:0] fn);
      logic [2:0] op_v;
      case (fn)
         FN_ADD:  op_v = 3'b001;
         FN_SUB:  op_v = 3'b010;
         FN_AND:  op_v = 3'b011;
         default: op_v = 3'b001;
      endcase
      return op_v;
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             wait_done_s;
   logic             ovf_trap_s;

   assign wait_done_s = (cnt_r == WAIT_C);
   assign state_o     = state_r;

   // State register and memory wait counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_RESET;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

`ifdef CTRL_OVF_EXC_EN
   logic ovf_r;

   // Overflow flag captured during the execute cycle, consumed at write-back
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_r <= 1'b0;
      end else if ((state_r == S_EXEC_R) || (state_r == S_EXEC_I)) begin
         ovf_r <= Of;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf_trap_s = ovf_r;
`else
   logic unused_of_s;
   assign unused_of_s = Of;
   assign ovf_trap_s  = 1'b0;
`endif

   // Next-state, wait counter and datapath control decode
   always_comb begin
      state_nxt_s = S_RESET;
      cnt_nxt_s   = {CNT_W{1'b0}};
      PC_w        = 1'b0;
      MEM_w       = 1'b0;
      IR_w        = 1'b0;
      MDR_w       = 1'b0;
      RB_w        = 1'b0;
      AB_w        = 1'b0;
      ALUOut_w    = 1'b0;
      EPC_w       = 1'b0;
      ULA_c       = 3'b000;
      M_IORD      = 1'b0;
      M_WREG      = 1'b0;
      M_WDATA     = 1'b0;
      M_ULAA      = 2'd0;
      M_ULAB      = 2'd0;
      M_PCSRC     = 2'd0;

      case (state_r)
         S_RESET: begin
            state_nxt_s = S_FETCH;
         end
         S_FETCH: begin
            if (wait_done_s) begin
               IR_w        = 1'b1;
               PC_w        = 1'b1;
               M_ULAB      = 2'd1;
               ULA_c       = 3'b001;
               state_nxt_s = S_DECODE;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_W'(1);
               state_nxt_s = S_FETCH;
            end
         end
         S_DECODE: begin
            // Speculatively compute the branch target into ALUOut
            AB_w     = 1'b1;
            ALUOut_w = 1'b1;
            M_ULAB   = 2'd3;
            ULA_c    = 3'b001;
            case (OPCODE)
               OP_RTYPE: begin
                  if (funct_valid(FUNCT)) begin
                     state_nxt_s = S_EXEC_R;
                  end else begin
                     state_nxt_s = S_EXC;
                  end
               end
               OP_ADDI:        state_nxt_s = S_EXEC_I;
               OP_LW, OP_SW:   state_nxt_s = S_MEM_ADDR;
               OP_BEQ, OP_BNE: state_nxt_s = S_BRANCH;
               OP_J:           state_nxt_s = S_JUMP;
               default:        state_nxt_s = S_EXC;
            endcase
         end
         S_EXEC_R: begin
            M_ULAA      = 2'd1;
            ULA_c       = alu_from_funct(FUNCT);
            ALUOut_w    = 1'b1;
            state_nxt_s = S_WB_R;
         end
         S_WB_R: begin
            M_WREG = 1'b1;
            if (ovf_trap_s && (FUNCT != FN_AND)) begin
               state_nxt_s = S_EXC;
            end else begin
               RB_w        = 1'b1;
               state_nxt_s = S_FETCH;
            end
         end
         S_EXEC_I: begin
            M_ULAA      = 2'd1;
            M_ULAB      = 2'd2;
            ULA_c       = 3'b001;
            ALUOut_w    = 1'b1;
            state_nxt_s = S_WB_I;
         end
         S_WB_I: begin
            if (ovf_trap_s) begin
               state_nxt_s = S_EXC;
            end else begin
               RB_w        = 1'b1;
               state_nxt_s = S_FETCH;
            end
         end
         S_MEM_ADDR: begin
            M_ULAA   = 2'd1;
            M_ULAB   = 2'd2;
            ULA_c    = 3'b001;
            ALUOut_w = 1'b1;
            if (OPCODE == OP_SW) begin
               state_nxt_s = S_MEM_WR;
            end else begin
               state_nxt_s = S_MEM_RD;
            end
         end
         S_MEM_RD: begin
            M_IORD = 1'b1;
            if (wait_done_s) begin
               MDR_w       = 1'b1;
               state_nxt_s = S_WB_LW;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_W'(1);
               state_nxt_s = S_MEM_RD;
            end
         end
         S_WB_LW: begin
            RB_w        = 1'b1;
            M_WDATA     = 1'b1;
            state_nxt_s = S_FETCH;
         end
         S_MEM_WR: begin
            M_IORD      = 1'b1;
            MEM_w       = 1'b1;
            state_nxt_s = S_FETCH;
         end
         S_BRANCH: begin
            M_ULAA  = 2'd1;
            ULA_c   = 3'b111;
            M_PCSRC = 2'd1;
            if (OPCODE == OP_BNE) begin
               PC_w = ~Eq;
            end else begin
               PC_w = Eq;
            end
            state_nxt_s = S_FETCH;
         end
         S_JUMP: begin
            PC_w        = 1'b1;
            M_PCSRC     = 2'd2;
            state_nxt_s = S_FETCH;
         end
         S_EXC: begin
            // PC already points past the faulting instruction; PC-4 goes to EPC
            EPC_w       = 1'b1;
            M_ULAB      = 2'd1;
            ULA_c       = 3'b010;
            state_nxt_s = S_EXC_VEC;
         end
         S_EXC_VEC: begin
            PC_w        = 1'b1;
            M_PCSRC     = 2'd3;
            state_nxt_s = S_FETCH;
         end
         default: begin
            state_nxt_s = S_RESET;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction control-word sequence model
// is queued ahead of each instruction and compared against the DUT every cycle.
module tb_multicycle_ctrl;
   localparam int MEM_WAIT = 1;
   localparam int CNT_W    = 2;
`ifdef CTRL_OVF_EXC_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   // enable bits of the control word, MSB first
   localparam logic [7:0] E_PC  = 8'h80;
   localparam logic [7:0] E_MEM = 8'h40;
   localparam logic [7:0] E_IR  = 8'h20;
   localparam logic [7:0] E_MDR = 8'h10;
   localparam logic [7:0] E_RB  = 8'h08;
   localparam logic [7:0] E_AB  = 8'h04;
   localparam logic [7:0] E_ALO = 8'h02;
   localparam logic [7:0] E_EPC = 8'h01;
   localparam logic [2:0] S_IORD  = 3'b100;
   localparam logic [2:0] S_WREG  = 3'b010;
   localparam logic [2:0] S_WDATA = 3'b001;

   logic       clk, reset;
   logic [5:0] OPCODE, FUNCT;
   logic       Of, Eq;
   logic       PC_w, MEM_w, IR_w, MDR_w, RB_w, AB_w, ALUOut_w, EPC_w;
   logic [2:0] ULA_c;
   logic       M_IORD, M_WREG, M_WDATA;
   logic [1:0] M_ULAA, M_ULAB, M_PCSRC;
   logic [3:0] state_o;

   int          n_vec = 0;
   int          n_err = 0;
   int          step_idx = 0;
   string       cur_name = "init";
   logic [19:0] exp_q[$];
   logic [19:0] dut_cw;

   assign dut_cw = {PC_w, MEM_w, IR_w, MDR_w, RB_w, AB_w, ALUOut_w, EPC_w,
                    ULA_c, M_IORD, M_WREG, M_WDATA, M_ULAA, M_ULAB, M_PCSRC};

   multicycle_ctrl #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Of(Of), .Eq(Eq),
      .PC_w(PC_w), .MEM_w(MEM_w), .IR_w(IR_w), .MDR_w(MDR_w), .RB_w(RB_w),
      .AB_w(AB_w), .ALUOut_w(ALUOut_w), .EPC_w(EPC_w), .ULA_c(ULA_c),
      .M_IORD(M_IORD), .M_WREG(M_WREG), .M_WDATA(M_WDATA), .M_ULAA(M_ULAA),
      .M_ULAB(M_ULAB), .M_PCSRC(M_PCSRC), .state_o(state_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [19:0] cw(input logic [7:0] en, input logic [2:0] ula,
                                      input logic [2:0] sel, input logic [1:0] ulaa,
                                      input logic [1:0] ulab, input logic [1:0] pcsrc);
      return {en, ula, sel, ulaa, ulab, pcsrc};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic push_exc();
      exp_q.push_back(cw(E_EPC, 3'b010, 3'b000, 2'd0, 2'd1, 2'd0));
      exp_q.push_back(cw(E_PC, 3'b000, 3'b000, 2'd0, 2'd0, 2'd3));
   endtask

   // Expected control words, one per cycle, for one instruction from its first FETCH cycle
   task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic of);
      logic       trap;
      logic [2:0] alu;
      for (int i = 0; i < MEM_WAIT; i++) exp_q.push_back(20'h0);
      exp_q.push_back(cw(E_PC | E_IR, 3'b001, 3'b000, 2'd0, 2'd1, 2'd0));
      exp_q.push_back(cw(E_AB | E_ALO, 3'b001, 3'b000, 2'd0, 2'd3, 2'd0));
      if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
         alu  = (fn == 6'h20) ? 3'b001 : ((fn == 6'h22) ? 3'b010 : 3'b011);
         trap = OVF_EN && of && (fn != 6'h24);
         exp_q.push_back(cw(E_ALO, alu, 3'b000, 2'd1, 2'd0, 2'd0));
         exp_q.push_back(cw(trap ? 8'h00 : E_RB, 3'b000, S_WREG, 2'd0, 2'd0, 2'd0));
         if (trap) push_exc();
      end else if (op == 6'h08) begin
         trap = OVF_EN && of;
         exp_q.push_back(cw(E_ALO, 3'b001, 3'b000, 2'd1, 2'd2, 2'd0));
         exp_q.push_back(cw(trap ? 8'h00 : E_RB, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0));
         if (trap) push_exc();
      end else if (op == 6'h23) begin
         exp_q.push_back(cw(E_ALO, 3'b001, 3'b000, 2'd1, 2'd2, 2'd0));
         for (int i = 0; i < MEM_WAIT; i++) exp_q.push_back(cw(8'h00, 3'b000, S_IORD, 2'd0, 2'd0, 2'd0));
         exp_q.push_back(cw(E_MDR, 3'b000, S_IORD, 2'd0, 2'd0, 2'd0));
         exp_q.push_back(cw(E_RB, 3'b000, S_WDATA, 2'd0, 2'd0, 2'd0));
      end else if (op == 6'h2B) begin
         exp_q.push_back(cw(E_ALO, 3'b001, 3'b000, 2'd1, 2'd2, 2'd0));
         exp_q.push_back(cw(E_MEM, 3'b000, S_IORD, 2'd0, 2'd0, 2'd0));
      end else if (op == 6'h04 || op == 6'h05) begin
         exp_q.push_back(cw(((op == 6'h04) ? eq : !eq) ? E_PC : 8'h00, 3'b111, 3'b000, 2'd1, 2'd0, 2'd1));
      end else if (op == 6'h02) begin
         exp_q.push_back(cw(E_PC, 3'b000, 3'b000, 2'd0, 2'd0, 2'd2));
      end else begin
         push_exc();
      end
   endtask

   // Per-cycle comparison of DUT control word against the queued model
   always @(negedge clk) begin : cmp_blk
      logic [19:0] e;
      string       nm;
      if (exp_q.size() != 0) begin
         e  = exp_q.pop_front();
         nm = $sformatf("%s[cyc%0d]", cur_name, step_idx);
         step_idx++;
         check(nm, {12'h0, dut_cw}, {12'h0, e});
      end
   end

   task automatic drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 64) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout %s: got %0d words pending, expected 0", cur_name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic start_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                              input logic eq, input logic of);
      cur_name = name;
      step_idx = 0;
      OPCODE   = op;
      FUNCT    = fn;
      Eq       = eq;
      Of       = of;
      model_instr(op, fn, eq, of);
   endtask

   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic eq, input logic of);
      start_instr(name, op, fn, eq, of);
      drain();
   endtask

   initial begin
      reset  = 1'b1;
      OPCODE = 6'h00;
      FUNCT  = 6'h00;
      Of     = 1'b0;
      Eq     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {28'h0, state_o}, 32'h0);
      check("reset_cw", {12'h0, dut_cw}, 32'h0);

      reset    = 1'b0;
      cur_name = "reset_release";
      step_idx = 0;
      exp_q.push_back(20'h0);
      drain();

      // add, with the model pinned against hand-computed words
      start_instr("add", 6'h00, 6'h20, 1'b0, 1'b0);
      check("model_add_len", 32'(exp_q.size()), 32'd5);
      check("model_fetch_word", {12'h0, exp_q[1]}, 32'h000A0204);
      check("model_wbr_word", {12'h0, exp_q[4]}, 32'h00008080);
      drain();

      run_instr("sub", 6'h00, 6'h22, 1'b0, 1'b0);
      run_instr("and_of", 6'h00, 6'h24, 1'b1, 1'b1);
      run_instr("add_of", 6'h00, 6'h20, 1'b0, 1'b1);
      run_instr("addi", 6'h08, 6'h11, 1'b0, 1'b0);
      run_instr("addi_of", 6'h08, 6'h00, 1'b0, 1'b1);

      start_instr("lw", 6'h23, 6'h05, 1'b0, 1'b0);
      check("model_lw_len", 32'(exp_q.size()), 32'd7);
      check("model_lw_rd1", {12'h0, exp_q[4]}, 32'h00000100);
      check("model_lw_rd2", {12'h0, exp_q[5]}, 32'h00010100);
      check("model_lw_wb", {12'h0, exp_q[6]}, 32'h00008040);
      drain();

      run_instr("sw", 6'h2B, 6'h00, 1'b0, 1'b0);

      start_instr("beq_taken", 6'h04, 6'h00, 1'b1, 1'b0);
      check("model_beq_len", 32'(exp_q.size()), 32'd4);
      check("model_beq_word", {12'h0, exp_q[3]}, 32'h00080E11);
      drain();
      run_instr("beq_not_taken", 6'h04, 6'h00, 1'b0, 1'b0);
      run_instr("bne_eq", 6'h05, 6'h00, 1'b1, 1'b0);
      run_instr("bne_ne", 6'h05, 6'h00, 1'b0, 1'b0);
      run_instr("jump", 6'h02, 6'h3A, 1'b0, 1'b0);

      start_instr("bad_opcode", 6'h3F, 6'h00, 1'b0, 1'b0);
      check("model_exc_len", 32'(exp_q.size()), 32'd5);
      check("model_exc_epc", {12'h0, exp_q[3]}, 32'h00001404);
      check("model_exc_vec", {12'h0, exp_q[4]}, 32'h00080003);
      drain();
      run_instr("bad_funct", 6'h00, 6'h21, 1'b0, 1'b0);

      // reset pulse landing in the second FETCH cycle
      cur_name = "rst_mid_fetch";
      step_idx = 0;
      OPCODE   = 6'h00;
      FUNCT    = 6'h20;
      exp_q.push_back(20'h0);
      drain();
      check("fetch2_ir_w", {31'h0, IR_w}, 32'h1);
      reset = 1'b1;
      #1;
      check("rst_mid_state", {28'h0, state_o}, 32'h0);
      check("rst_mid_cw", {12'h0, dut_cw}, 32'h0);
      @(posedge clk);
      #1;
      check("rst_held_cw", {12'h0, dut_cw}, 32'h0);
      reset = 1'b0;
      exp_q.push_back(20'h0);
      drain();

      run_instr("add_after_reset", 6'h00, 6'h20, 1'b0, 1'b0);
      run_instr("jump_final", 6'h02, 6'h00, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control unit FSM for the multicycle MIPS-subset CPU.
- Decodes OPCODE/FUNCT from the instruction register and ALU flags.
- Drives every register write enable, mux select and ULA_c operation code in the datapath, including memory wait states and exception entry (EPC + vector).
- Sits directly upstream of the datapath; the datapath consumes every output it produces.

Parameters:
- MEM_WAIT, 1, extra cycles a memory read needs before data is valid (0..3).
- CNT_W, 2, width of the wait counter; must hold MEM_WAIT.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- OPCODE  in  6  instr[31:26]
- FUNCT  in  6  instr[5:0]
- Of  in  1  ULA overflow
- Eq  in  1  ULA equal flag
- PC_w  out  1  PC write
- MEM_w  out  1  memory write
- IR_w  out  1  IR write
- MDR_w  out  1  memory data reg write
- RB_w  out  1  register bank write
- AB_w  out  1  A/B write
- ALUOut_w  out  1  ALUOut write
- EPC_w  out  1  EPC write
- ULA_c  out  3  000 loadA, 001 add, 010 sub, 011 and, 111 compare
- M_IORD  out  1  mem addr: 0 PC, 1 ALUOut
- M_WREG  out  1  dest: 0 RT, 1 RD
- M_WDATA  out  1  write data: 0 ALUOut, 1 MDR
- M_ULAA  out  2  0 PC, 1 A
- M_ULAB  out  2  0 B, 1 const 4, 2 SXTND, 3 SL2
- M_PCSRC  out  2  0 ULA_out, 1 ALUOut, 2 jump target, 3 exception vector
- state_o  out  4  current state (debug)

Behaviour:
- Outputs are decoded combinationally from state, wait counter, OPCODE, FUNCT and flags. Unlisted enables = 0; unlisted selects = 0.
- reset asserted: state=RESET and counter=0 immediately. All enables 0 while reset is held, including reset mid-instruction.
- Supported instructions:
  - R-type (OPCODE 0): add 0x20, sub 0x22, and 0x24.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02.
- RESET: no enables; next FETCH.
- FETCH: M_IORD=0; counter increments each cycle. When counter==MEM_WAIT: IR_w=1, PC_w=1, M_ULAA=0, M_ULAB=1, ULA_c=001, M_PCSRC=0; counter cleared; next DECODE.
- DECODE: AB_w=1, ALUOut_w=1, M_ULAA=0, M_ULAB=3, ULA_c=001 (branch target). Next state by opcode:
  - 0 with valid funct -> EXEC_R
  - 0x08 -> EXEC_I
  - 0x23/0x2B -> MEM_ADDR
  - 0x04/0x05 -> BRANCH
  - 0x02 -> JUMP
  - otherwise (incl. invalid funct) -> EXC
- EXEC_R: M_ULAA=1, M_ULAB=0, ULA_c from funct (add 001, sub 010, and 011), ALUOut_w=1; next WB_R.
- WB_R: RB_w=1, M_WREG=1, M_WDATA=0; next FETCH.
- EXEC_I: M_ULAA=1, M_ULAB=2, ULA_c=001, ALUOut_w=1; next WB_I.
- WB_I: RB_w=1, M_WREG=0, M_WDATA=0; next FETCH.
- MEM_ADDR: M_ULAA=1, M_ULAB=2, ULA_c=001, ALUOut_w=1; next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: M_IORD=1; counter as in FETCH. When counter==MEM_WAIT: MDR_w=1; next WB_LW.
- WB_LW: RB_w=1, M_WREG=0, M_WDATA=1; next FETCH.
- MEM_WR: M_IORD=1, MEM_w=1 for exactly one cycle; next FETCH.
- BRANCH: M_ULAA=1, M_ULAB=0, ULA_c=111, M_PCSRC=1.
  - PC_w = Eq for beq, PC_w = !Eq for bne.
  - Next FETCH.
- JUMP: PC_w=1, M_PCSRC=2; next FETCH.
- EXC: EPC_w=1, M_ULAA=0, M_ULAB=1, ULA_c=010 (PC-4 = faulting instr); next EXC_VEC.
- EXC_VEC: PC_w=1, M_PCSRC=3; next FETCH.
- Latency with MEM_WAIT=1: R/addi 5 cycles, lw 7, sw 5, beq/bne/j 4, exception 5.
- Counter saturates at MEM_WAIT and is never left nonzero outside FETCH/MEM_RD.
- Any undefined state encoding -> RESET next cycle.

Optional Feature:
- CTRL_OVF_EXC_EN defined:
  - In WB_R (add/sub) and WB_I, if Of was latched high during the EXEC cycle: RB_w=0 and next state is EXC. The fault instruction address is saved in EPC.
  - Of is latched in a 1-bit register written in EXEC_R/EXEC_I; the latch is cleared by reset.
- Undefined: Of ignored, result written; the latch is not present.

Test Plan:
- Reset pulse mid-FETCH (counter=1) -> state_o=RESET, all enables 0 same cycle; after release, FETCH next edge.
- OPCODE=0, FUNCT=0x20, MEM_WAIT=1 -> IR_w/PC_w in FETCH cycle 2, AB_w cycle 3, ULA_c=001 cycle 4, RB_w=1 with M_WREG=1 cycle 5, FETCH cycle 6.
- OPCODE=0x23 -> MEM_RD asserts M_IORD=1 for 2 cycles, MDR_w on second, WB_LW RB_w=1 M_WDATA=1.
- OPCODE=0x04 with Eq=1 -> PC_w=1 M_PCSRC=1; with Eq=0 -> PC_w=0; OPCODE=0x05 inverse.
- OPCODE=0x3F -> EPC_w=1 ULA_c=010 then PC_w=1 M_PCSRC=3, then FETCH.
- OPCODE=0x08 with Of=1 in EXEC_I -> with CTRL_OVF_EXC_EN: RB_w stays 0, EPC_w=1 next; without it: RB_w=1, FETCH.
